rv32i_exec_ctrl: RTL and testbench

Multi-cycle execute controller that drives the team's RV32I ALU. It is the initiator side of the ALU interface: it produces operands and a 4-bit ALU op code, then samples the ALU's combinational result and zero flag. It accepts one pre-fetched instruction, with operands, through a valid/ready handshake. It returns writeback data, the next PC and the branch decision as a one-cycle done pulse.

---
 rtl/rv32i_pkg.sv | 64 ++++++
 rtl/rv32i_imm_gen.sv | 28 ++
 rtl/rv32i_exec_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rv32i_exec_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Brief    : Opcodes, ALU op encodings, controller states and immediate types.
// Revision : 1.0
// ============================================================================
package rv32i_pkg;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_BGEU = 4'b1001,
        ALU_BLTU = 4'b1010,
        ALU_BGE  = 4'b1011,
        ALU_BLT  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_BNE  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        TGT  = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    // Branch ops are chosen so the ALU result is zero exactly when the branch is taken.
    function automatic alu_op_e branch_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_SUB;
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            3'b111:  return ALU_BGEU;
            default: return ALU_SUB;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_imm_gen
// Brief    : Combinational I/S/B/U/J immediate extraction with sign extension.
// Revision : 1.0
// ============================================================================
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] inst,
    input  logic [2:0]  sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (sel)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'd0};
            IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_exec_ctrl
// Brief    : Multi-cycle RV32I execute controller driving an external ALU.
// Revision : 1.0
// ============================================================================
module rv32i_exec_ctrl
    import rv32i_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit RESET_IDLE_READY = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [XLEN-1:0] o_alu_a,
    output logic [XLEN-1:0] o_alu_b,
    output logic [3:0]      o_alu_op,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_alu_zero,
    output logic            o_done,
    output logic            o_rd_we,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_branch_taken,
    output logic            o_illegal
);

    state_e          r_state;
    state_e          w_next_state;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_target;
    logic            r_zero;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic            w_is_op, w_is_opimm, w_is_lui, w_is_auipc;
    logic            w_is_branch, w_is_jal, w_is_jalr;
    logic            w_bad_op, w_bad_branch, w_illegal;
    logic            w_two_pass, w_writes_rd, w_taken, w_accept;
    logic [2:0]      w_imm_sel;
    logic [31:0]     w_imm;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_opcode = r_inst[6:0];
    assign w_f3     = r_inst[14:12];
    assign w_f7     = r_inst[31:25];
    assign w_rd     = r_inst[11:7];

    assign w_is_op     = (w_opcode == c_opc_op);
    assign w_is_opimm  = (w_opcode == c_opc_op_imm);
    assign w_is_lui    = (w_opcode == c_opc_lui);
    assign w_is_auipc  = (w_opcode == c_opc_auipc);
    assign w_is_branch = (w_opcode == c_opc_branch);
    assign w_is_jal    = (w_opcode == c_opc_jal);
    assign w_is_jalr   = (w_opcode == c_opc_jalr);

    assign w_bad_branch = w_is_branch && (w_f3[2:1] == 2'b01);
    assign w_bad_op     = w_is_op &&
                          (((w_f7 != 7'h00) && (w_f7 != 7'h20)) ||
                           ((w_f7 == 7'h20) && (w_f3 != 3'b000) && (w_f3 != 3'b101)));
    assign w_illegal    = w_bad_op || w_bad_branch ||
                          !(w_is_op || w_is_opimm || w_is_lui || w_is_auipc ||
                            w_is_branch || w_is_jal || w_is_jalr);

    assign w_two_pass  = (w_is_branch && !w_bad_branch) || w_is_jal || w_is_jalr;
    assign w_writes_rd = w_is_op || w_is_opimm || w_is_lui || w_is_auipc || w_is_jal || w_is_jalr;
    assign w_taken     = !w_illegal && (w_is_jal || w_is_jalr || (w_is_branch && r_zero));
    assign w_pc_plus4  = r_pc + 32'd4;

    assign o_ready  = (r_state == IDLE) && (RESET_IDLE_READY || i_rst_n);
    assign w_accept = i_valid && o_ready;

    rv32i_imm_gen u_imm_gen (
        .inst (r_inst[31:7]),
        .sel  (w_imm_sel),
        .imm  (w_imm)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_alu_a      = '0;
        o_alu_b      = '0;
        o_alu_op     = ALU_ADD;
        w_imm_sel    = IMM_I;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = w_two_pass ? TGT : WB;
                if (!w_illegal) begin
                    if (w_is_op) begin
                        o_alu_a  = r_rs1;
                        o_alu_b  = r_rs2;
                        o_alu_op = {w_f7[5], w_f3};
                    end else if (w_is_opimm) begin
                        o_alu_a  = r_rs1;
                        o_alu_b  = w_imm;
                        o_alu_op = {(w_f3 == 3'b101) & w_f7[5], w_f3};
                    end else if (w_is_lui || w_is_auipc) begin
                        w_imm_sel = IMM_U;
                        o_alu_a   = w_is_auipc ? r_pc : '0;
                        o_alu_b   = w_imm;
                    end else if (w_is_branch) begin
                        o_alu_a  = r_rs1;
                        o_alu_b  = r_rs2;
                        o_alu_op = branch_op(w_f3);
                    end else begin
                        // JAL/JALR: first pass produces the link value.
                        o_alu_a = r_pc;
                        o_alu_b = 32'd4;
                    end
                end
            end
            TGT: begin
                w_next_state = WB;
                if (w_is_jalr) begin
                    o_alu_a = r_rs1;
                    o_alu_b = w_imm;
                end else begin
                    w_imm_sel = w_is_branch ? IMM_B : IMM_J;
                    o_alu_a   = r_pc;
                    o_alu_b   = w_imm;
                end
            end
            WB: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst         <= '0;
            r_pc           <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_result       <= '0;
            r_target       <= '0;
            r_zero         <= 1'b0;
            o_done         <= 1'b0;
            o_rd_we        <= 1'b0;
            o_rd_addr      <= '0;
            o_rd_data      <= '0;
            o_next_pc      <= '0;
            o_branch_taken <= 1'b0;
            o_illegal      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_inst <= i_inst;
                        r_pc   <= i_pc;
                        r_rs1  <= i_rs1_data;
                        r_rs2  <= i_rs2_data;
                    end
                end
                EXEC: begin
                    r_result <= i_alu_result;
                    r_zero   <= i_alu_zero;
                end
                TGT: begin
                    r_target <= w_is_jalr ? {i_alu_result[XLEN-1:1], 1'b0} : i_alu_result;
                end
                WB: begin
                    o_done         <= 1'b1;
                    o_rd_we        <= w_writes_rd && (w_rd != 5'd0) && !w_illegal;
                    o_rd_addr      <= w_rd;
                    o_rd_data      <= r_result;
                    o_next_pc      <= w_taken ? r_target : w_pc_plus4;
                    o_branch_taken <= w_taken;
                    o_illegal      <= w_illegal;
                end
                default: begin
                    o_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_exec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rv32i_exec_ctrl
// Brief    : Directed plus random bench with an ALU model and ISA-level reference.
// Revision : 1.0
// ============================================================================
module tb_rv32i_exec_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_inst = '0, i_pc = '0, i_rs1_data = '0, i_rs2_data = '0;
    logic [31:0] o_alu_a, o_alu_b, i_alu_result;
    logic [3:0]  o_alu_op;
    logic        i_alu_zero;
    logic        o_done, o_rd_we, o_branch_taken, o_illegal;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data, o_next_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    rv32i_exec_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero),
        .o_done(o_done), .o_rd_we(o_rd_we), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
        .o_next_pc(o_next_pc), .o_branch_taken(o_branch_taken), .o_illegal(o_illegal)
    );

    // Team ALU: branch ops return zero when their condition holds.
    always_comb begin
        case (o_alu_op)
            4'b0000: i_alu_result = o_alu_a + o_alu_b;
            4'b0001: i_alu_result = o_alu_a << o_alu_b[4:0];
            4'b0010: i_alu_result = ($signed(o_alu_a) < $signed(o_alu_b)) ? 32'd1 : 32'd0;
            4'b0011: i_alu_result = (o_alu_a < o_alu_b) ? 32'd1 : 32'd0;
            4'b0100: i_alu_result = o_alu_a ^ o_alu_b;
            4'b0101: i_alu_result = o_alu_a >> o_alu_b[4:0];
            4'b0110: i_alu_result = o_alu_a | o_alu_b;
            4'b0111: i_alu_result = o_alu_a & o_alu_b;
            4'b1000: i_alu_result = o_alu_a - o_alu_b;
            4'b1001: i_alu_result = (o_alu_a >= o_alu_b) ? 32'd0 : 32'd1;
            4'b1010: i_alu_result = (o_alu_a < o_alu_b) ? 32'd0 : 32'd1;
            4'b1011: i_alu_result = ($signed(o_alu_a) >= $signed(o_alu_b)) ? 32'd0 : 32'd1;
            4'b1100: i_alu_result = ($signed(o_alu_a) < $signed(o_alu_b)) ? 32'd0 : 32'd1;
            4'b1101: i_alu_result = $signed(o_alu_a) >>> o_alu_b[4:0];
            4'b1111: i_alu_result = (o_alu_a != o_alu_b) ? 32'd0 : 32'd1;
            default: i_alu_result = 32'd0;
        endcase
        i_alu_zero = (i_alu_result == 32'd0);
    end

    typedef struct {
        logic        wr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] npc;
        logic        taken;
        logic        ill;
        logic [3:0]  op;
        int          lat;
    } exp_t;

    function automatic logic [31:0] rv_arith(input logic [2:0] f3, input logic alt,
                                             input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic [31:0] r;
        sx = x;
        case (f3)
            3'd0: r = alt ? (x - y) : (x + y);
            3'd1: r = x << y[4:0];
            3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: r = (x < y) ? 32'd1 : 32'd0;
            3'd4: r = x ^ y;
            3'd5: begin
                if (alt) r = sx >>> y[4:0];
                else     r = x >> y[4:0];
            end
            3'd6: r = x | y;
            default: r = x & y;
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [31:0] ii, iu, ib, ij;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        cond;
        f3 = inst[14:12];
        f7 = inst[31:25];
        ii = {{20{inst[31]}}, inst[31:20]};
        iu = {inst[31:12], 12'd0};
        ib = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        ij = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        e.wr = 0; e.we = 0; e.rd = inst[11:7]; e.data = 0; e.npc = pc + 32'd4;
        e.taken = 0; e.ill = 0; e.op = 4'd0; e.lat = 2; cond = 0;
        case (inst[6:0])
            7'b0110011: begin
                if ((f7 != 7'h00 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5))
                    e.ill = 1;
                else begin
                    e.wr = 1; e.data = rv_arith(f3, f7[5], x, y); e.op = {f7[5], f3};
                end
            end
            7'b0010011: begin
                e.wr = 1;
                e.data = rv_arith(f3, (f3 == 3'd5) && f7[5], x, ii);
                e.op = {(f3 == 3'd5) && f7[5], f3};
            end
            7'b0110111: begin e.wr = 1; e.data = iu; end
            7'b0010111: begin e.wr = 1; e.data = pc + iu; end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1;
                else begin
                    e.lat = 3;
                    case (f3)
                        3'd0: begin cond = (x == y); e.op = 4'b1000; end
                        3'd1: begin cond = (x != y); e.op = 4'b1111; end
                        3'd4: begin cond = ($signed(x) < $signed(y)); e.op = 4'b1100; end
                        3'd5: begin cond = ($signed(x) >= $signed(y)); e.op = 4'b1011; end
                        3'd6: begin cond = (x < y); e.op = 4'b1010; end
                        default: begin cond = (x >= y); e.op = 4'b1001; end
                    endcase
                    e.taken = cond;
                    if (cond) e.npc = pc + ib;
                end
            end
            7'b1101111: begin
                e.wr = 1; e.data = pc + 32'd4; e.npc = pc + ij; e.taken = 1; e.lat = 3;
            end
            7'b1100111: begin
                e.wr = 1; e.data = pc + 32'd4; e.npc = (x + ii) & ~32'd1; e.taken = 1; e.lat = 3;
            end
            default: e.ill = 1;
        endcase
        e.we = e.wr && (e.rd != 5'd0) && !e.ill;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] x,
                       input logic [31:0] y, input bit hold, input string tag);
        exp_t e;
        int lat;
        bit got, extra;
        logic [67:0] prev_alu;
        e = model(inst, pc, x, y);
        @(negedge i_clk);
        check({tag, " ready_idle"}, {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_inst = inst; i_pc = pc; i_rs1_data = x; i_rs2_data = y;
        @(posedge i_clk);
        @(negedge i_clk);
        if (!e.ill) check({tag, " exec_op"}, {28'd0, o_alu_op}, {28'd0, e.op});
        if (!hold) i_valid = 1'b0;
        lat = 0; got = 0; prev_alu = '0;
        while (!got && lat < 8) begin
            if (hold) check({tag, " busy_ready"}, {31'd0, o_ready}, 32'd0);
            prev_alu = {o_alu_a, o_alu_b, o_alu_op};
            @(posedge i_clk);
            @(negedge i_clk);
            lat++;
            if (o_done) got = 1;
        end
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        if (got) begin
            check({tag, " alu_wb_zero"}, {31'd0, (prev_alu != 68'd0)}, 32'd0);
            check({tag, " alu_idle_zero"}, {31'd0, ({o_alu_a, o_alu_b, o_alu_op} != 68'd0)}, 32'd0);
            check({tag, " rd_we"}, {31'd0, o_rd_we}, {31'd0, e.we});
            check({tag, " rd_addr"}, {27'd0, o_rd_addr}, {27'd0, e.rd});
            check({tag, " next_pc"}, o_next_pc, e.npc);
            check({tag, " taken"}, {31'd0, o_branch_taken}, {31'd0, e.taken});
            check({tag, " illegal"}, {31'd0, o_illegal}, {31'd0, e.ill});
            if (e.wr) check({tag, " rd_data"}, o_rd_data, e.data);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        check({tag, " done_pulse"}, {31'd0, o_done}, 32'd0);
        check({tag, " next_pc_hold"}, o_next_pc, e.npc);
        if (hold) begin
            extra = 0;
            repeat (4) begin
                @(negedge i_clk);
                if (o_done || !o_ready) extra = 1;
            end
            check({tag, " single_accept"}, {31'd0, extra}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] inst, pc, x, y;
        logic [2:0]  f3;
        logic [2:0]  bf3 [6];
        int          t;
        bit          rst_done;
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        repeat (2) @(negedge i_clk);
        check("rst ready", {31'd0, o_ready}, 32'd1);
        check("rst done", {31'd0, o_done}, 32'd0);
        check("rst outs", {31'd0, ({o_rd_we, o_rd_addr, o_rd_data, o_next_pc, o_branch_taken, o_illegal} != 0)}, 32'd0);
        check("rst alu_op", {28'd0, o_alu_op}, 32'd0);
        i_rst_n = 1'b1;

        run(32'h002081B3, 32'h40, 32'd5, 32'd7, 0, "add");
        run(32'h4040D293, 32'h44, 32'h80000000, 32'd0, 0, "srai");
        run(32'h00209863, 32'h100, 32'd1, 32'd2, 0, "bne_t");
        run(32'h00209863, 32'h100, 32'd2, 32'd2, 0, "bne_nt");
        run(32'h00002003, 32'h300, 32'd9, 32'd9, 1, "load_hold");
        run(32'h002081B3, 32'hFFFFFFFC, 32'd1, 32'd2, 0, "pc_wrap");
        run(32'h00208033, 32'h80, 32'd3, 32'd4, 0, "add_x0");
        run(32'h022081B3, 32'h84, 32'd3, 32'd4, 0, "op_badf7");
        run(32'h0020A063, 32'h88, 32'd3, 32'd3, 0, "br_f3_010");
        run(32'h003100E7, 32'h200, 32'h1001, 32'd0, 0, "jalr");

        // Abort an instruction while it is in its target pass.
        @(negedge i_clk);
        i_valid = 1'b1; i_inst = 32'h00209863; i_pc = 32'h100; i_rs1_data = 1; i_rs2_data = 2;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("abort ready", {31'd0, o_ready}, 32'd1);
        check("abort outs", {31'd0, ({o_rd_we, o_rd_addr, o_rd_data, o_next_pc, o_branch_taken, o_illegal} != 0)}, 32'd0);
        check("abort alu", {31'd0, ({o_alu_a, o_alu_b, o_alu_op} != 68'd0)}, 32'd0);
        rst_done = 0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_done) rst_done = 1;
        end
        check("abort no_done", {31'd0, rst_done}, 32'd0);
        i_rst_n = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            if (o_done) rst_done = 1;
        end
        check("abort no_done_after", {31'd0, rst_done}, 32'd0);
        run(32'h002081B3, 32'h40, 32'd5, 32'd7, 0, "add_after_rst");

        for (int k = 0; k < 60; k++) begin
            inst = $urandom;
            pc   = $urandom & 32'hFFFFFFFC;
            x    = $urandom;
            y    = ($urandom_range(0, 3) == 0) ? x : $urandom;
            f3   = 3'($urandom_range(0, 7));
            t    = $urandom_range(0, 8);
            case (t)
                0: begin
                    inst[6:0] = 7'b0110011; inst[14:12] = f3;
                    inst[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                1: begin
                    inst[6:0] = 7'b0010011; inst[14:12] = f3;
                    if (f3 == 3'd1) inst[31:25] = 7'h00;
                    if (f3 == 3'd5) inst[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                2: inst[6:0] = 7'b0110111;
                3: inst[6:0] = 7'b0010111;
                4, 5: begin
                    inst[6:0] = 7'b1100011; inst[14:12] = bf3[$urandom_range(0, 5)];
                end
                6: inst[6:0] = 7'b1101111;
                7: begin inst[6:0] = 7'b1100111; inst[14:12] = 3'd0; end
                default: begin
                    case ($urandom_range(0, 3))
                        0: inst[6:0] = 7'b0000011;
                        1: inst[6:0] = 7'b0100011;
                        2: begin inst[6:0] = 7'b1100011; inst[14:12] = 3'($urandom_range(2, 3)); end
                        default: begin inst[6:0] = 7'b0110011; inst[31:25] = 7'h01; end
                    endcase
                end
            endcase
            run(inst, pc, x, y, 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
